// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file for the pipelined CPU.
// Two write ports (pipeline writeback and mult/div) with port 0 winning
// same-address collisions, write-through bypass on both read ports, a
// per-register busy scoreboard for pending multi-cycle results, and a
// registered per-port write trace for the debug log.
module grf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic [31:0]   pc0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [31:0]   pc1,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_a,
    output logic          tr0_v,
    output logic [31:0]   tr0_pc,
    output logic [AW-1:0] tr0_a,
    output logic [DW-1:0] tr0_d,
    output logic          tr1_v,
    output logic [31:0]   tr1_pc,
    output logic [AW-1:0] tr1_a,
    output logic [DW-1:0] tr1_d
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nx;

    logic we0_eff, we1_eff, we1_keep, rsv_eff;
    logic r1_zero, r2_zero;
    logic hit01, hit11, hit02, hit12;

    // Register 0 is hard-wired when ZERO_REG is set: no writes, no reservations.
    assign we0_eff  = we0 & ~(ZERO_REG & (wa0 == '0));
    assign we1_eff  = we1 & ~(ZERO_REG & (wa1 == '0));
    assign rsv_eff  = rsv_en & ~(ZERO_REG & (rsv_a == '0));
    // A port-1 write to the same register as a port-0 write is dropped.
    assign we1_keep = we1_eff & ~(we0_eff & (wa0 == wa1));

    assign r1_zero = ZERO_REG & (ra1 == '0);
    assign r2_zero = ZERO_REG & (ra2 == '0);
    assign hit01   = we0_eff & (wa0 == ra1);
    assign hit11   = we1_eff & (wa1 == ra1);
    assign hit02   = we0_eff & (wa0 == ra2);
    assign hit12   = we1_eff & (wa1 == ra2);

    // Read port 1: zero register, then port-0 bypass, then port-1 bypass, then array.
    always_comb begin
        if (r1_zero)    rd1 = '0;
        else if (hit01) rd1 = wd0;
        else if (hit11) rd1 = wd1;
        else            rd1 = mem[ra1];
        busy1 = busy[ra1] & ~hit01 & ~hit11 & ~r1_zero;
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if (r2_zero)    rd2 = '0;
        else if (hit02) rd2 = wd0;
        else if (hit12) rd2 = wd1;
        else            rd2 = mem[ra2];
        busy2 = busy[ra2] & ~hit02 & ~hit12 & ~r2_zero;
    end

    // Scoreboard next state: writes clear, then a new reservation (younger producer) sets.
    always_comb begin
        busy_nx = busy;
        if (we0_eff) busy_nx[wa0] = 1'b0;
        if (we1_eff) busy_nx[wa1] = 1'b0;
        if (rsv_eff) busy_nx[rsv_a] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nx;
    end

    // Register array update; reset clears every entry and discards pending writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we1_keep) mem[wa1] <= wd1;
            if (we0_eff)  mem[wa0] <= wd0;
        end
    end

    // Write trace: records what each port issued, holding payload while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tr0_v  <= 1'b0;
            tr0_pc <= '0;
            tr0_a  <= '0;
            tr0_d  <= '0;
            tr1_v  <= 1'b0;
            tr1_pc <= '0;
            tr1_a  <= '0;
            tr1_d  <= '0;
        end else begin
            tr0_v <= we0_eff;
            tr1_v <= we1_eff;
            if (we0_eff) begin
                tr0_pc <= pc0;
                tr0_a  <= wa0;
                tr0_d  <= wd0;
            end
            if (we1_eff) begin
                tr1_pc <= pc1;
                tr1_a  <= wa1;
                tr1_d  <= wd1;
            end
        end
    end
endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: one instance with ZERO_REG=1 (k=0) and one
// with ZERO_REG=0 (k=1) share all inputs and are checked against a
// behavioural register-file model.
module tb_grf_mp;
    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2, wa0, wa1, rsv_a;
    logic [31:0] wd0, wd1, pc0, pc1;
    logic        we0, we1, rsv_en;

    logic [31:0] rd1_k [2];
    logic [31:0] rd2_k [2];
    logic        busy1_k [2];
    logic        busy2_k [2];
    logic        tr0_v_k [2];
    logic [31:0] tr0_pc_k [2];
    logic [4:0]  tr0_a_k [2];
    logic [31:0] tr0_d_k [2];
    logic        tr1_v_k [2];
    logic [31:0] tr1_pc_k [2];
    logic [4:0]  tr1_a_k [2];
    logic [31:0] tr1_d_k [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance
    bit [31:0] mm [2][32];
    bit        mb [2][32];
    bit        mtv [2][2];
    bit [31:0] mtpc [2][2];
    bit [4:0]  mta [2][2];
    bit [31:0] mtd [2][2];

    grf_mp #(.DW(32), .AW(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_k[0]), .rd2(rd2_k[0]), .busy1(busy1_k[0]), .busy2(busy2_k[0]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
        .rsv_en(rsv_en), .rsv_a(rsv_a),
        .tr0_v(tr0_v_k[0]), .tr0_pc(tr0_pc_k[0]), .tr0_a(tr0_a_k[0]), .tr0_d(tr0_d_k[0]),
        .tr1_v(tr1_v_k[0]), .tr1_pc(tr1_pc_k[0]), .tr1_a(tr1_a_k[0]), .tr1_d(tr1_d_k[0])
    );

    grf_mp #(.DW(32), .AW(5), .ZERO_REG(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_k[1]), .rd2(rd2_k[1]), .busy1(busy1_k[1]), .busy2(busy2_k[1]),
        .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
        .rsv_en(rsv_en), .rsv_a(rsv_a),
        .tr0_v(tr0_v_k[1]), .tr0_pc(tr0_pc_k[1]), .tr0_a(tr0_a_k[1]), .tr0_d(tr0_d_k[1]),
        .tr1_v(tr1_v_k[1]), .tr1_pc(tr1_pc_k[1]), .tr1_a(tr1_a_k[1]), .tr1_d(tr1_d_k[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Is register a of instance k the hard-wired zero?
    function automatic bit is_zero(int k, logic [4:0] a);
        return (k == 0) && (a == 5'd0);
    endfunction

    function automatic bit eff0(int k);
        return we0 && !is_zero(k, wa0);
    endfunction

    function automatic bit eff1(int k);
        return we1 && !is_zero(k, wa1);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
        if (is_zero(k, ra)) return 32'd0;
        if (eff0(k) && wa0 == ra) return wd0;
        if (eff1(k) && wa1 == ra) return wd1;
        return mm[k][ra];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] ra);
        if (is_zero(k, ra)) return 1'b0;
        if (eff0(k) && wa0 == ra) return 1'b0;
        if (eff1(k) && wa1 == ra) return 1'b0;
        return mb[k][ra];
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    mm[k][i] = 0;
                    mb[k][i] = 0;
                end
                for (int p = 0; p < 2; p++) begin
                    mtv[k][p] = 0; mtpc[k][p] = 0; mta[k][p] = 0; mtd[k][p] = 0;
                end
            end else begin
                mtv[k][0] = eff0(k);
                mtv[k][1] = eff1(k);
                if (eff0(k)) begin mtpc[k][0] = pc0; mta[k][0] = wa0; mtd[k][0] = wd0; end
                if (eff1(k)) begin mtpc[k][1] = pc1; mta[k][1] = wa1; mtd[k][1] = wd1; end
                if (eff1(k) && !(eff0(k) && wa0 == wa1)) mm[k][wa1] = wd1;
                if (eff0(k)) mm[k][wa0] = wd0;
                if (eff0(k)) mb[k][wa0] = 0;
                if (eff1(k)) mb[k][wa1] = 0;
                if (rsv_en && !is_zero(k, rsv_a)) mb[k][rsv_a] = 1;
            end
        end
    endtask

    // Advance one clock: model consumes current inputs, DUT sees the posedge.
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; we0 = 0; we1 = 0; rsv_en = 0;
    endtask

    task automatic test_reset();
        reset = 1; we0 = 1; wa0 = 5'd2; wd0 = 32'hCAFE; pc0 = 32'h100;
        we1 = 1; wa1 = 5'd3; wd1 = 32'hBEEF; pc1 = 32'h104;
        rsv_en = 1; rsv_a = 5'd2; ra1 = 5'd2; ra2 = 5'd3;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'd0) begin errors++; $display("FAIL reset_rd1 k=%0d got=%h exp=0", k, rd1_k[k]); end
            checks++; if (rd2_k[k] !== 32'd0) begin errors++; $display("FAIL reset_rd2 k=%0d got=%h exp=0", k, rd2_k[k]); end
            checks++; if (busy1_k[k] !== 1'b0 || busy2_k[k] !== 1'b0) begin errors++; $display("FAIL reset_busy k=%0d got=%b%b exp=00", k, busy1_k[k], busy2_k[k]); end
            checks++; if (tr0_v_k[k] !== 1'b0 || tr1_v_k[k] !== 1'b0) begin errors++; $display("FAIL reset_trv k=%0d got=%b%b exp=00", k, tr0_v_k[k], tr1_v_k[k]); end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] pc;
        pc = $urandom;
        idle(); we0 = 1; wa0 = 5'd5; wd0 = 32'h1234; pc0 = pc; ra1 = 5'd5; ra2 = 5'd6;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'h1234) begin errors++; $display("FAIL bypass_same k=%0d got=%h exp=1234", k, rd1_k[k]); end
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'h1234) begin errors++; $display("FAIL bypass_next k=%0d got=%h exp=1234", k, rd1_k[k]); end
            checks++; if (tr0_v_k[k] !== 1'b1 || tr0_a_k[k] !== 5'd5 || tr0_pc_k[k] !== pc) begin
                errors++; $display("FAIL bypass_trace k=%0d got v=%b a=%0d pc=%h exp v=1 a=5 pc=%h", k, tr0_v_k[k], tr0_a_k[k], tr0_pc_k[k], pc);
            end
        end
    endtask

    task automatic test_zero_reg();
        idle(); we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF; we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF; ra1 = 5'd0;
        #1;
        checks++; if (rd1_k[0] !== 32'd0) begin errors++; $display("FAIL zero_same got=%h exp=0", rd1_k[0]); end
        tick();
        idle();
        #1;
        checks++; if (rd1_k[0] !== 32'd0) begin errors++; $display("FAIL zero_next got=%h exp=0", rd1_k[0]); end
        checks++; if (tr0_v_k[0] !== 1'b0 || tr1_v_k[0] !== 1'b0) begin errors++; $display("FAIL zero_trv got=%b%b exp=00", tr0_v_k[0], tr1_v_k[0]); end
        checks++; if (rd1_k[1] !== 32'hFFFF) begin errors++; $display("FAIL nozero_next got=%h exp=ffff", rd1_k[1]); end
        checks++; if (tr0_v_k[1] !== 1'b1 || tr1_v_k[1] !== 1'b1) begin errors++; $display("FAIL nozero_trv got=%b%b exp=11", tr0_v_k[1], tr1_v_k[1]); end
    endtask

    task automatic test_collision();
        idle(); we0 = 1; wa0 = 5'd7; wd0 = 32'hA; we1 = 1; wa1 = 5'd7; wd1 = 32'hB; ra1 = 5'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'hA) begin errors++; $display("FAIL coll_same k=%0d got=%h exp=a", k, rd1_k[k]); end
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'hA) begin errors++; $display("FAIL coll_next k=%0d got=%h exp=a", k, rd1_k[k]); end
            checks++; if (tr0_v_k[k] !== 1'b1 || tr1_v_k[k] !== 1'b1 || tr1_d_k[k] !== 32'hB) begin
                errors++; $display("FAIL coll_trace k=%0d got v=%b%b d1=%h exp v=11 d1=b", k, tr0_v_k[k], tr1_v_k[k], tr1_d_k[k]);
            end
        end
    endtask

    task automatic test_scoreboard();
        idle(); rsv_en = 1; rsv_a = 5'd9; ra1 = 5'd9;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy1_k[k] !== 1'b1) begin errors++; $display("FAIL sb_set k=%0d got=%b exp=1", k, busy1_k[k]); end
        end
        tick();
        we1 = 1; wa1 = 5'd9; wd1 = 32'h55;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy1_k[k] !== 1'b0 || rd1_k[k] !== 32'h55) begin errors++; $display("FAIL sb_wr_same k=%0d got busy=%b rd=%h exp busy=0 rd=55", k, busy1_k[k], rd1_k[k]); end
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy1_k[k] !== 1'b0 || rd1_k[k] !== 32'h55) begin errors++; $display("FAIL sb_wr_next k=%0d got busy=%b rd=%h exp busy=0 rd=55", k, busy1_k[k], rd1_k[k]); end
        end
    endtask

    task automatic test_rsv_and_write();
        idle(); rsv_en = 1; rsv_a = 5'd3; we0 = 1; wa0 = 5'd3; wd0 = 32'h77; ra2 = 5'd3;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy2_k[k] !== 1'b1 || rd2_k[k] !== 32'h77) begin errors++; $display("FAIL rsv_wr k=%0d got busy=%b rd=%h exp busy=1 rd=77", k, busy2_k[k], rd2_k[k]); end
        end
    endtask

    task automatic test_reset_mid();
        idle(); rsv_en = 1; rsv_a = 5'd4; we0 = 1; wa0 = 5'd6; wd0 = 32'h66;
        tick();
        idle(); ra1 = 5'd4; ra2 = 5'd6;
        #1;
        checks++; if (busy1_k[0] !== 1'b1 || rd2_k[0] !== 32'h66) begin errors++; $display("FAIL pre_reset got busy=%b rd2=%h exp busy=1 rd2=66", busy1_k[0], rd2_k[0]); end
        reset = 1; we0 = 1; wa0 = 5'd4; wd0 = 32'hDEAD; we1 = 1; wa1 = 5'd6; wd1 = 32'hBEEF; rsv_en = 1; rsv_a = 5'd6;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'd0 || rd2_k[k] !== 32'd0) begin errors++; $display("FAIL mid_reset_rd k=%0d got=%h,%h exp=0,0", k, rd1_k[k], rd2_k[k]); end
            checks++; if (busy1_k[k] !== 1'b0 || busy2_k[k] !== 1'b0) begin errors++; $display("FAIL mid_reset_busy k=%0d got=%b%b exp=00", k, busy1_k[k], busy2_k[k]); end
            checks++; if (tr0_v_k[k] !== 1'b0 || tr1_v_k[k] !== 1'b0) begin errors++; $display("FAIL mid_reset_trv k=%0d got=%b%b exp=00", k, tr0_v_k[k], tr1_v_k[k]); end
        end
        we1 = 1; wa1 = 5'd4; wd1 = 32'h99;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (rd1_k[k] !== 32'h99 || busy1_k[k] !== 1'b0) begin errors++; $display("FAIL post_reset_wr k=%0d got rd=%h busy=%b exp rd=99 busy=0", k, rd1_k[k], busy1_k[k]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 59) == 0);
            we0    = $urandom_range(0, 1);
            we1    = $urandom_range(0, 1);
            rsv_en = ($urandom_range(0, 2) == 0);
            wa0    = 5'($urandom_range(0, 7));
            wa1    = 5'($urandom_range(0, 7));
            rsv_a  = 5'($urandom_range(0, 7));
            ra1    = 5'($urandom_range(0, 7));
            ra2    = 5'($urandom_range(0, 7));
            wd0    = $urandom;
            wd1    = $urandom;
            pc0    = $urandom;
            pc1    = $urandom;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (rd1_k[k] !== exp_rd(k, ra1)) begin errors++; $display("FAIL rnd_rd1 n=%0d k=%0d got=%h exp=%h", n, k, rd1_k[k], exp_rd(k, ra1)); end
                checks++; if (rd2_k[k] !== exp_rd(k, ra2)) begin errors++; $display("FAIL rnd_rd2 n=%0d k=%0d got=%h exp=%h", n, k, rd2_k[k], exp_rd(k, ra2)); end
                checks++; if (busy1_k[k] !== exp_busy(k, ra1) || busy2_k[k] !== exp_busy(k, ra2)) begin
                    errors++; $display("FAIL rnd_busy n=%0d k=%0d got=%b%b exp=%b%b", n, k, busy1_k[k], busy2_k[k], exp_busy(k, ra1), exp_busy(k, ra2));
                end
                checks++; if (tr0_v_k[k] !== mtv[k][0] || tr0_pc_k[k] !== mtpc[k][0] || tr0_a_k[k] !== mta[k][0] || tr0_d_k[k] !== mtd[k][0]) begin
                    errors++; $display("FAIL rnd_tr0 n=%0d k=%0d got v=%b pc=%h a=%0d d=%h exp v=%b pc=%h a=%0d d=%h", n, k,
                        tr0_v_k[k], tr0_pc_k[k], tr0_a_k[k], tr0_d_k[k], mtv[k][0], mtpc[k][0], mta[k][0], mtd[k][0]);
                end
                checks++; if (tr1_v_k[k] !== mtv[k][1] || tr1_pc_k[k] !== mtpc[k][1] || tr1_a_k[k] !== mta[k][1] || tr1_d_k[k] !== mtd[k][1]) begin
                    errors++; $display("FAIL rnd_tr1 n=%0d k=%0d got v=%b pc=%h a=%0d d=%h exp v=%b pc=%h a=%0d d=%h", n, k,
                        tr1_v_k[k], tr1_pc_k[k], tr1_a_k[k], tr1_d_k[k], mtv[k][1], mtpc[k][1], mta[k][1], mtd[k][1]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1; we0 = 0; we1 = 0; rsv_en = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; pc0 = 0; pc1 = 0;
        rsv_a = 0; ra1 = 0; ra2 = 0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_rsv_and_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised multi-port general register file for the pipelined CPU. It replaces the single-write GRF: two independent write ports (main pipeline writeback and the multi-cycle mult/div unit), write-through bypass on both read ports, and a per-register busy scoreboard so decode can stall on pending multi-cycle results. It also emits a registered per-port write trace (PC, address, data) for the grading/debug log. It sits in decode: reads feed the operand muxes, and writes arrive from W stage and the mult/div unit.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2^AW registers
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and reservations; 0 = register 0 is an ordinary register
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset, sampled on posedge clk
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  DW  read data (combinational, bypassed)
- busy1, busy2  out  1  register at ra1/ra2 has an outstanding reservation not satisfied this cycle
- we0, wa0, wd0, pc0  in  1/AW/DW/32  write port 0 (pipeline writeback) enable, address, data, instruction PC
- we1, wa1, wd1, pc1  in  1/AW/DW/32  write port 1 (mult/div writeback), same meaning
- rsv_en, rsv_a  in  1/AW  reserve register rsv_a (mark busy) at this posedge
- tr0_v, tr0_pc, tr0_a, tr0_d  out  1/32/AW/DW  registered trace of the port-0 write accepted at the previous edge
- tr1_v, tr1_pc, tr1_a, tr1_d  out  1/32/AW/DW  same for port 1

## Operation
- Effective write: wePk_eff = weK & !(ZERO_REG & waK==0).
- Same-address collision (we0_eff & we1_eff & wa0==wa1): port 0 wins and the port-1 write is dropped. tr1_v still reports it, with tr1_a/tr1_d as presented; the trace shows what was issued.
- Read data for port n:
  - If ZERO_REG and ran==0: 0.
  - Else if we0_eff & wa0==ran: wd0.
  - Else if we1_eff & wa1==ran: wd1.
  - Else: mem[ran].
- Scoreboard: one busy bit per register.
  - Set on rsv_en when rsv_a is non-zero (or ZERO_REG=0).
  - Cleared by any effective write to that address.
  - Reserve and write to the same address in the same cycle: busy ends at 1, because the new reservation is for a younger producer.
- busyN = busy[ran] & !(a bypass hit on ran this cycle). A register at address 0 with ZERO_REG=1 always gives busyN = 0.
- Trace: at each posedge, trK_v <= weK_eff; trK_pc/a/d <= pcK/waK/wdK. The trace holds its value when trK_v=0.

## Timing
- Reads, bypass and busyN are combinational from inputs and state in the same cycle.
- Writes, busy updates and trace are visible from the next cycle. Write-to-read latency through the array is 1 cycle; it is 0 via the bypass.
- Reset, at posedge with reset=1:
  - All mem cleared to 0, all busy to 0, tr0_v=tr1_v=0, trace data/pc/addr to 0.
  - Writes and reservations presented in the reset cycle are discarded.
- Reset mid-reservation clears busy. A mult/div write arriving after reset still writes normally, with no error.
- Outputs after reset, with idle inputs: rd1=rd2=0, busy1=busy2=0, tr*_v=0.

## Test plan
- Reset, then write r5=0x1234 via port 0 -> same-cycle rd1 (ra1=5) = 0x1234 (bypass). The next cycle reads 0x1234 from the array, and tr0_v=1, tr0_a=5, tr0_pc equals the driven pc0.
- Write r0=0xFFFF on both ports with ZERO_REG=1 -> rd1(ra1=0)=0, tr0_v=tr1_v=0. With ZERO_REG=0 the same write returns 0xFFFF on the next cycle.
- Collision: we0 r7=0xA, we1 r7=0xB -> rd1(r7)=0xA same cycle and next cycle; tr0_v=tr1_v=1 with tr1_d=0xB.
- Scoreboard: rsv r9 -> busy1(ra1=9)=1 the next cycle. we1 r9=0x55 in a later cycle -> that cycle busy1=0, rd1=0x55; the following cycle busy1=0, rd1=0x55.
- Same-cycle rsv r3 plus we0 r3=0x77 -> the next cycle has busy on r3 =1 and rd(r3)=0x77.
- Reserve r4 and write r4/r6, then assert reset for 1 cycle -> all rd=0, busy=0, tr*_v=0. Writes in the reset cycle are not stored.
